// File: rtl/keypad_scanner_deb_if.sv
// ============================================================================
// keypad_scanner_deb_if : keypad row/column lines and decoded key outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface keypad_scanner_deb_if #(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4
);
  localparam int KEY_W = $clog2(N_ROWS * N_COLS);

  logic [N_ROWS-1:0] filas;
  logic [N_COLS-1:0] columnas;
  logic [KEY_W-1:0]  key_code;
  logic              key_valid;
  logic              key_held;
  logic              key_release;
  logic              multi_key;

  // master: the scanner; slave: keypad matrix plus the consumer of key events
  modport master (
    input  filas,
    output columnas, key_code, key_valid, key_held, key_release, multi_key
  );

  modport slave (
    output filas,
    input  columnas, key_code, key_valid, key_held, key_release, multi_key
  );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner_deb.sv
// ============================================================================
// keypad_scanner_deb : parametrised matrix keypad scanner, frame-level debounce
// Rev 1.0
// ============================================================================
`default_nettype none

module keypad_scanner_deb #(
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 4,
  parameter int SCAN_DIV   = 5,
  parameter int DEB_FRAMES = 3
) (
  input  wire logic           clk,
  input  wire logic           rst,
  keypad_scanner_deb_if.master bus
);

  localparam int KEY_W   = $clog2(N_ROWS * N_COLS);
  localparam int c_div_w = $clog2(SCAN_DIV);
  localparam int c_col_w = $clog2(N_COLS);
  localparam int c_row_w = $clog2(N_ROWS);
  localparam int c_cnt_w = $clog2(DEB_FRAMES + 1);

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(N_COLS - 1);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_deb      = c_cnt_w'(DEB_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DEB_PRESS = 2'd1,
    S_PRESSED   = 2'd2,
    S_DEB_REL   = 2'd3
  } state_t;

  logic [N_ROWS-1:0]  r_sync_meta;
  logic [N_ROWS-1:0]  r_sync;
  logic [c_div_w-1:0] r_dwell;
  logic [c_col_w-1:0] r_col;
  logic [N_COLS-1:0]  r_columnas;
  logic               r_frame_end;
  logic [1:0]         r_hits;
  logic [KEY_W-1:0]   r_last;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [KEY_W-1:0]   r_cand;
  logic [KEY_W-1:0]   r_key_code;
  logic               r_key_held;
  logic               r_key_valid;
  logic               r_key_release;
  logic               r_multi_key;

  logic               w_sample;
  logic               w_last_col;
  logic [c_col_w-1:0] w_col_next;
  logic [1:0]         w_col_hits;
  logic [c_row_w-1:0] w_col_row;
  logic [KEY_W-1:0]   w_col_idx;
  logic [2:0]         w_hit_sum;
  logic               w_single;
  logic               w_multi;
  logic               w_match;
  logic [c_cnt_w-1:0] w_cnt_inc;

  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [KEY_W-1:0]   w_cand_nxt;
  logic [KEY_W-1:0]   w_code_nxt;
  logic               w_held_nxt;
  logic               w_valid_nxt;
  logic               w_rel_nxt;
  logic               w_multi_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= '1;
      r_sync      <= '1;
    end else begin
      r_sync_meta <= bus.filas;
      r_sync      <= r_sync_meta;
    end
  end

  assign w_sample   = (r_dwell == c_div_last);
  assign w_last_col = (r_col == c_col_last);
  assign w_col_next = w_last_col ? '0 : r_col + c_col_w'(1);

  // Column drive moves on the same edge that samples the column being left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell     <= '0;
      r_col       <= '0;
      r_columnas  <= ~N_COLS'(1);
      r_frame_end <= 1'b0;
    end else begin
      r_frame_end <= w_sample && w_last_col;
      if (w_sample) begin
        r_dwell    <= '0;
        r_col      <= w_col_next;
        r_columnas <= ~(N_COLS'(1) << w_col_next);
      end else begin
        r_dwell <= r_dwell + c_div_w'(1);
      end
    end
  end

  // Hits in the current column, saturating at 2; the highest asserted row wins
  always_comb begin
    w_col_hits = 2'd0;
    w_col_row  = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (!r_sync[r]) begin
        w_col_row = c_row_w'(r);
        if (w_col_hits != 2'd2) begin
          w_col_hits = w_col_hits + 2'd1;
        end
      end
    end
  end

  assign w_col_idx = KEY_W'(int'(w_col_row) * N_COLS + int'(r_col));
  assign w_hit_sum = {1'b0, r_hits} + {1'b0, w_col_hits};

  // The evaluation edge is never a sample edge, so clearing here cannot drop a hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits <= 2'd0;
      r_last <= '0;
    end else if (r_frame_end) begin
      r_hits <= 2'd0;
      r_last <= '0;
    end else if (w_sample && (w_col_hits != 2'd0)) begin
      r_hits <= (w_hit_sum > 3'd2) ? 2'd2 : w_hit_sum[1:0];
      r_last <= w_col_idx;
    end
  end

  assign w_single  = (r_hits == 2'd1);
  assign w_multi   = (r_hits == 2'd2);
  assign w_match   = w_single && (r_last == r_key_code);
  assign w_cnt_inc = r_cnt + c_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cand        <= '0;
      r_key_code    <= '0;
      r_key_held    <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;
      r_multi_key   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cand        <= w_cand_nxt;
      r_key_code    <= w_code_nxt;
      r_key_held    <= w_held_nxt;
      r_key_valid   <= w_valid_nxt;
      r_key_release <= w_rel_nxt;
      r_multi_key   <= w_multi_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_code_nxt  = r_key_code;
    w_held_nxt  = r_key_held;
    w_valid_nxt = 1'b0;
    w_rel_nxt   = 1'b0;
    w_multi_nxt = r_frame_end && w_multi;
    if (r_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            if (DEB_FRAMES == 1) begin
              w_code_nxt  = r_last;
              w_valid_nxt = 1'b1;
              w_held_nxt  = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_PRESSED;
            end else begin
              w_cand_nxt  = r_last;
              w_cnt_nxt   = c_one;
              w_state_nxt = S_DEB_PRESS;
            end
          end
        end
        S_DEB_PRESS: begin
          if (w_single && (r_last == r_cand)) begin
            if (w_cnt_inc >= c_deb) begin
              w_code_nxt  = r_cand;
              w_valid_nxt = 1'b1;
              w_held_nxt  = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_PRESSED;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else if (w_single) begin
            w_cand_nxt = r_last;
            w_cnt_nxt  = c_one;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (w_match) begin
            w_cnt_nxt = '0;
          end else if (DEB_FRAMES == 1) begin
            w_held_nxt  = 1'b0;
            w_rel_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = c_one;
            w_state_nxt = S_DEB_REL;
          end
        end
        S_DEB_REL: begin
          if (w_match) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_PRESSED;
          end else if (w_cnt_inc >= c_deb) begin
            // A different key still down must be re-debounced from idle
            w_held_nxt  = 1'b0;
            w_rel_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.columnas    = r_columnas;
  assign bus.key_code    = r_key_code;
  assign bus.key_valid   = r_key_valid;
  assign bus.key_held    = r_key_held;
  assign bus.key_release = r_key_release;
  assign bus.multi_key   = r_multi_key;

endmodule

`default_nettype wire
